imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_byte_packer.sv | 33 +++
 rtl/imem_loader.sv | 128 ++++++++++++
 tb/tb_imem_loader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the serial instruction-memory loader.
package imem_loader_pkg;

    localparam logic [7:0] MAGIC   = 8'hA5;
    localparam int         COUNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN0  = 3'd1,
        ST_LEN1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_CSUM  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles four accepted bytes (little-endian) into a 32-bit word.
// packed_word/word_complete are combinational views that include the byte being accepted.
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] packed_word,
    output logic        word_complete
);

    logic [31:0] shreg;
    logic [1:0]  byte_cnt;

    // Bytes enter at the top so the first byte ends up in bits [7:0].
    assign packed_word   = {byte_in, shreg[31:8]};
    assign word_complete = byte_valid && (byte_cnt == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg    <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            shreg    <= '0;
            byte_cnt <= '0;
        end else if (byte_valid) begin
            shreg    <= packed_word;
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Receives a framed instruction image over a byte stream, writes it into
// instruction memory and holds the core in reset until the checksum verifies.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        load_start,
    output logic        imem_write_en,
    output logic [31:0] imem_write_addr,
    output logic [31:0] imem_write_data,
    output logic        core_reset,
    output logic        imem_read_en,
    output logic        load_done,
    output logic        load_error
);

    state_t             state;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] word_index;
    logic [COUNT_W-1:0] full_count;
    logic [7:0]         csum;
    logic               accept;
    logic               pk_valid;
    logic               pk_clear;
    logic [31:0]        pk_word;
    logic               pk_complete;

    assign accept     = rx_valid && rx_ready;
    assign pk_valid   = accept && (state == ST_DATA);
    assign pk_clear   = (state != ST_DATA);
    assign full_count = {rx_data, count[7:0]};

    byte_packer u_packer (
        .clk           (clk),
        .reset         (reset),
        .clear         (pk_clear),
        .byte_valid    (pk_valid),
        .byte_in       (rx_data),
        .packed_word   (pk_word),
        .word_complete (pk_complete)
    );

    // The write-strobe cycle is a bubble: no byte is taken while a word is committed.
    always_comb begin
        rx_ready = 1'b0;
        case (state)
            ST_IDLE, ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM: rx_ready = !imem_write_en;
            default:                                     rx_ready = 1'b0;
        endcase
    end

    assign load_done    = (state == ST_DONE);
    assign imem_read_en = (state == ST_DONE);
    assign core_reset   = (state != ST_DONE);
    assign load_error   = (state == ST_ERROR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            count           <= '0;
            word_index      <= '0;
            csum            <= '0;
            imem_write_en   <= 1'b0;
            imem_write_addr <= BASE_ADDR;
            imem_write_data <= '0;
        end else begin
            imem_write_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept && (rx_data == MAGIC)) begin
                        state      <= ST_LEN0;
                        csum       <= '0;
                        count      <= '0;
                        word_index <= '0;
                    end
                end
                ST_LEN0: begin
                    if (accept) begin
                        count[7:0] <= rx_data;
                        state      <= ST_LEN1;
                    end
                end
                ST_LEN1: begin
                    if (accept) begin
                        count[15:8] <= rx_data;
                        if (full_count == '0)
                            state <= ST_CSUM;
                        else if ({16'b0, full_count} > 32'(DEPTH_WORDS))
                            state <= ST_ERROR;
                        else
                            state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (imem_write_en) begin
                        word_index <= word_index + 1'b1;
                        if (word_index == count - 1'b1)
                            state <= ST_CSUM;
                    end else if (accept) begin
                        csum <= csum ^ rx_data;
                        if (pk_complete) begin
                            imem_write_en   <= 1'b1;
                            imem_write_addr <= BASE_ADDR + {14'b0, word_index, 2'b00};
                            imem_write_data <= pk_word;
                        end
                    end
                end
                ST_CSUM: begin
                    if (accept)
                        state <= (rx_data == csum) ? ST_DONE : ST_ERROR;
                end
                ST_DONE, ST_ERROR: begin
                    if (load_start)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of frames, write scoreboard, reset-abort sequence.
module tb_imem_loader;

    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        load_start = 1'b0;
    logic        imem_write_en;
    logic [31:0] imem_write_addr;
    logic [31:0] imem_write_data;
    logic        core_reset;
    logic        imem_read_en;
    logic        load_done;
    logic        load_error;

    imem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_valid        (rx_valid),
        .rx_data         (rx_data),
        .rx_ready        (rx_ready),
        .load_start      (load_start),
        .imem_write_en   (imem_write_en),
        .imem_write_addr (imem_write_addr),
        .imem_write_data (imem_write_data),
        .core_reset      (core_reset),
        .imem_read_en    (imem_read_en),
        .load_done       (load_done),
        .load_error      (load_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        string       name;
        int          ngarb;
        int          count;
        logic [31:0] w[8];
        logic [7:0]  csum;
        bit          auto_csum;
        bit          rnd;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input string n, input int ng, input int cnt, input logic [7:0] cs,
                                input bit auto_cs, input bit rnd, input bit done, input bit err);
        vec_t v;
        v.name = n; v.ngarb = ng; v.count = cnt; v.csum = cs; v.auto_csum = auto_cs;
        v.rnd = rnd; v.exp_done = done; v.exp_err = err;
        for (int i = 0; i < 8; i++) v.w[i] = '0;
        return v;
    endfunction

    // Scoreboard: every strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (imem_write_en) begin
            chk("rx_ready_during_strobe", {31'b0, rx_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: addr %h data %h, no write expected", imem_write_addr, imem_write_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", imem_write_addr, e.addr);
                chk("write_data", imem_write_data, e.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int waitc;
        if (rnd) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
            end
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        waitc = 0;
        while (!rx_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (!rx_ready) begin
            checks++;
            $display("FAIL rx_ready_timeout: byte %h not accepted, rx_ready %b after 20 cycles, expected 1", b, rx_ready);
            rx_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic idle_rx();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] cs;
        logic [15:0] c16;
        c16 = 16'(v.count);
        cs = v.csum;
        if (v.auto_csum) begin
            cs = 8'h00;
            for (int i = 0; i < v.count; i++)
                cs = cs ^ v.w[i][7:0] ^ v.w[i][15:8] ^ v.w[i][23:16] ^ v.w[i][31:24];
        end
        if (v.ngarb > 0) begin
            send_byte(8'h00, v.rnd);
            send_byte(8'hFF, v.rnd);
        end
        send_byte(8'hA5, v.rnd);
        send_byte(c16[7:0], v.rnd);
        send_byte(c16[15:8], v.rnd);
        if (v.count <= DEPTH) begin
            for (int i = 0; i < v.count; i++) begin
                wr_t e;
                e.addr = BASE + 32'(4 * i);
                e.data = v.w[i];
                exp_q.push_back(e);
            end
            for (int i = 0; i < v.count; i++)
                for (int k = 0; k < 4; k++)
                    send_byte(v.w[i][8*k +: 8], v.rnd);
            send_byte(cs, v.rnd);
        end
        idle_rx();
        repeat (2) @(negedge clk);
        chk($sformatf("%s.load_done", v.name), {31'b0, load_done}, {31'b0, v.exp_done});
        chk($sformatf("%s.load_error", v.name), {31'b0, load_error}, {31'b0, v.exp_err});
        chk($sformatf("%s.imem_read_en", v.name), {31'b0, imem_read_en}, {31'b0, v.exp_done});
        chk($sformatf("%s.core_reset", v.name), {31'b0, core_reset}, {31'b0, !v.exp_done});
        chk($sformatf("%s.rx_ready_parked", v.name), {31'b0, rx_ready}, 32'd0);
        chk($sformatf("%s.writes_pending", v.name), exp_q.size(), 32'd0);
        exp_q.delete();
        @(negedge clk); load_start = 1'b1;
        @(negedge clk); load_start = 1'b0;
        chk($sformatf("%s.rearm_error", v.name), {31'b0, load_error}, 32'd0);
        chk($sformatf("%s.rearm_done", v.name), {31'b0, load_done}, 32'd0);
        chk($sformatf("%s.rearm_core_reset", v.name), {31'b0, core_reset}, 32'd1);
        chk($sformatf("%s.rearm_rx_ready", v.name), {31'b0, rx_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

    initial begin
        // XOR of data bytes 13,00,00,00,93,00,10,00 is 8'h90; 8'h80 must be rejected.
        vecs[0] = mk("two_word", 0, 2, 8'h90, 0, 0, 1, 0);
        vecs[0].w[0] = 32'h0000_0013; vecs[0].w[1] = 32'h0010_0093;
        vecs[1] = mk("two_word_badsum", 0, 2, 8'h80, 0, 0, 0, 1);
        vecs[1].w[0] = 32'h0000_0013; vecs[1].w[1] = 32'h0010_0093;
        vecs[2] = mk("garbage_one_word", 2, 1, 8'h22, 0, 0, 1, 0);
        vecs[2].w[0] = 32'hDEAD_BEEF;
        vecs[3] = mk("count0_ok", 0, 0, 8'h00, 0, 0, 1, 0);
        vecs[4] = mk("count0_bad", 0, 0, 8'h01, 0, 0, 0, 1);
        vecs[5] = mk("count_too_big", 0, DEPTH + 1, 8'h00, 0, 0, 0, 1);
        vecs[6] = mk("four_word_rnd", 0, 4, 8'hCC, 0, 1, 1, 0);
        vecs[6].w[0] = 32'h1122_3344; vecs[6].w[1] = 32'h5566_7788;
        vecs[6].w[2] = 32'h99AA_BBCC; vecs[6].w[3] = 32'h0F0F_0F0F;
        vecs[7] = mk("full_depth_rnd", 0, DEPTH, 8'h00, 1, 1, 1, 0);
        for (int i = 0; i < DEPTH; i++) vecs[7].w[i] = 32'($urandom);

        repeat (3) @(negedge clk);
        chk("reset.write_en", {31'b0, imem_write_en}, 32'd0);
        chk("reset.write_addr", imem_write_addr, BASE);
        chk("reset.write_data", imem_write_data, 32'd0);
        chk("reset.core_reset", {31'b0, core_reset}, 32'd1);
        chk("reset.read_en", {31'b0, imem_read_en}, 32'd0);
        chk("reset.done", {31'b0, load_done}, 32'd0);
        chk("reset.error", {31'b0, load_error}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("reset.rx_ready", {31'b0, rx_ready}, 32'd1);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Abandon a frame mid-word with reset; nothing may be written.
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        @(negedge clk);
        rx_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("abort.write_en", {31'b0, imem_write_en}, 32'd0);
        chk("abort.write_addr", imem_write_addr, BASE);
        chk("abort.write_data", imem_write_data, 32'd0);
        chk("abort.core_reset", {31'b0, core_reset}, 32'd1);
        chk("abort.error", {31'b0, load_error}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort.rx_ready", {31'b0, rx_ready}, 32'd1);
        vecs[0] = mk("after_abort", 0, 1, 8'h00, 1, 0, 1, 0);
        vecs[0].w[0] = 32'h0000_0013;
        run_vec(vecs[0]);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
